// File: rtl/key_debounce.sv
// Debounces a raw mechanical key: synchronises it into clk_in, then accepts a new
// level only after it has been stable for DEBOUNCE_CYCLES consecutive clocks.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic key_in,
    output logic sig_db,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sig_q, sig_d;
    logic                   busy_q, busy_d;
    logic                   key_s;

    // Sync flops reset to the released level so no false press is seen after reset.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], key_in};
    assign key_s  = sync_q[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{KEY_ACTIVE_LOW}};
            state_q <= S_LOW;
            cnt_q   <= '0;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        case (state_q)
            S_LOW: begin
                sig_d = 1'b0;
                if (key_s) begin
                    state_d = S_RISE_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            S_RISE_CHK: begin
                sig_d = 1'b0;
                if (!key_s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    sig_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                sig_d = 1'b1;
                if (!key_s) begin
                    state_d = S_FALL_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            S_FALL_CHK: begin
                sig_d = 1'b1;
                if (key_s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    sig_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                sig_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == S_RISE_CHK) || (state_d == S_FALL_CHK);
    end

    assign sig_db = sig_q;
    assign busy   = busy_q;

endmodule
